sia_tx_controller: RTL and testbench
====================================

Name: sia_tx_controller

Overview:
Frames and sequences characters for the SIA transmitter shift register. A host pushes 8-bit characters into a small FIFO. The controller builds each UART frame (start bit, 5–8 data bits, optional parity, 1 or 2 stop bits) as a 16-bit shift-register image with a bit count, and loads it into the transmitter when the transmitter reports idle. It sits between the host-side register interface and the transmitter.

Parameters:
DEPTH, 8, FIFO depth in characters; power of two, 2..64
AW, 3, FIFO pointer width; log2(DEPTH)
BAUD_RATE_WIDTH, 32, width of baud divisor passed to transmitter
SHIFT_REG_WIDTH, 16, width of frame image
BITS_WIDTH, 5, width of frame bit count

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
wr_i  in  1  push wdat_i into FIFO
wdat_i  in  8  character to send, LSB first
flush_i  in  1  discard all queued characters
char_len_i  in  4  data bits per character (5..8)
stop2_i  in  1  1 = two stop bits
baud_i  in  BAUD_RATE_WIDTH  baud divisor forwarded on load
tx_idle_i  in  1  transmitter idle flag
tx_we_o  out  1  one-cycle load strobe to transmitter
tx_dat_o  out  SHIFT_REG_WIDTH  frame image
tx_bits_o  out  BITS_WIDTH  frame length in bits
tx_baud_o  out  BAUD_RATE_WIDTH  baud divisor latched at load
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
count_o  out  AW+1  characters queued
overflow_o  out  1  sticky: write attempted while full
busy_o  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset values: state IDLE, FIFO empty, count_o=0, empty_o=1, full_o=0, overflow_o=0, tx_we_o=0, tx_dat_o all ones, tx_bits_o=0, tx_baud_o=0.
- FIFO is a circular buffer with wrap-around pointers.
  - Write when not full: enqueue.
  - Write when full: dropped and overflow_o set; the write is not dropped if a pop occurs in the same cycle.
  - Simultaneous push and pop: both take effect and count is unchanged.
- flush_i: empties the FIFO the next cycle and wins over a same-cycle wr_i. It does not abort a frame already loaded. overflow_o is unaffected.
- Character length: char_len_i < 5 is treated as 5; char_len_i > 8 is treated as 8. N is the effective length.
- Frame image:
  - bit0 = 0 (start bit).
  - bits[N:1] = data, LSB first.
  - All higher bits = 1.
- Frame length: tx_bits_o = 1 + N + (stop2_i ? 2 : 1). Range 7..11.
- Configuration inputs are sampled only in the cycle the FSM leaves IDLE. Mid-frame changes affect the next frame only.
- FSM:
  - IDLE → LOAD when FIFO not empty and tx_idle_i=1. The FIFO head is popped and tx_dat_o, tx_bits_o and tx_baud_o are registered on this transition.
  - LOAD: tx_we_o=1 for exactly this cycle → SETTLE.
  - SETTLE: one cycle, covering the transmitter's idle flag lagging by one cycle → WAIT.
  - WAIT → IDLE when tx_idle_i=1.
- Latency: wr_i sampled into an empty FIFO at edge k with transmitter idle gives tx_we_o=1 between edges k+2 and k+3.
- Back-to-back: minimum spacing between tx_we_o pulses is the frame time plus 3 cycles.
- tx_we_o is never asserted while tx_idle_i=0 at the IDLE decision point.
- Reset mid-frame: controller returns to reset values immediately. The transmitter is reset by the same reset_i.

Optional Feature:
Macro SIA_TX_PARITY_EN adds parity_en_i (1) and parity_odd_i (1) inputs.
- With the macro and parity_en_i=1:
  - bit N+1 carries parity: XOR of the N data bits, inverted when parity_odd_i=1.
  - Stop bits start at bit N+2.
  - tx_bits_o increases by 1; maximum 12.
- Without the macro: no parity ports, no parity bit, and logic is identical to parity_en_i=0.

Test Plan:
1. Reset, then char_len_i=8, stop2_i=0, baud_i=4, tx_idle_i=1, write 0x55 → tx_we_o pulses once, tx_dat_o=0xFEAA, tx_bits_o=10, tx_baud_o=4.
2. char_len_i=5, stop2_i=1, write 0xFF → tx_dat_o=0xFFFE, tx_bits_o=8. char_len_i=3 gives the same result as 5.
3. With tx_idle_i held 0, write 9 bytes to DEPTH=8 → full_o=1, count_o=8, overflow_o=1. Then release tx_idle_i → 8 loads in FIFO order and empty_o=1 at the end.
4. Drive tx_idle_i low 1 cycle after each tx_we_o and high 100 cycles later → no second tx_we_o before tx_idle_i returns high. Spacing is at least 103 cycles.
5. Queue 3 bytes, assert flush_i while in WAIT → current frame is not disturbed, empty_o=1 next cycle, no further tx_we_o.
6. With SIA_TX_PARITY_EN, parity_en_i=1, parity_odd_i=0, char_len_i=8, write 0x07 → bit9=1, tx_bits_o=11, tx_dat_o=0xFE0E.

Source files
------------

// File: rtl/sia_tx_controller.sv
// SIA transmit controller: character FIFO, UART frame builder and load sequencer.
// Optional parity generation is enabled by defining SIA_TX_PARITY_EN.
module sia_tx_controller #(
   parameter int unsigned DEPTH           = 8,
   parameter int unsigned AW              = 3,
   parameter int unsigned BAUD_RATE_WIDTH = 32,
   parameter int unsigned SHIFT_REG_WIDTH = 16,
   parameter int unsigned BITS_WIDTH      = 5
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       wr_i,
   input  logic [7:0]                 wdat_i,
   input  logic                       flush_i,
   input  logic [3:0]                 char_len_i,
   input  logic                       stop2_i,
`ifdef SIA_TX_PARITY_EN
   input  logic                       parity_en_i,
   input  logic                       parity_odd_i,
`endif
   input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
   input  logic                       tx_idle_i,
   output logic                       tx_we_o,
   output logic [SHIFT_REG_WIDTH-1:0] tx_dat_o,
   output logic [BITS_WIDTH-1:0]      tx_bits_o,
   output logic [BAUD_RATE_WIDTH-1:0] tx_baud_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [AW:0]                count_o,
   output logic                       overflow_o,
   output logic                       busy_o
);

   localparam int unsigned CW = AW + 1;
   localparam int unsigned IW = $clog2(SHIFT_REG_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_WAIT} state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [7:0]                 r_mem [DEPTH];
   logic [AW-1:0]              r_wr_ptr;
   logic [AW-1:0]              r_rd_ptr;
   logic [AW:0]                r_count;
   logic [AW:0]                w_count_nxt;
   logic                       w_full;
   logic                       w_empty;
   logic                       w_pop;
   logic                       w_push;
   logic                       w_ovf;
   logic                       w_tx_we_nxt;
   logic [7:0]                 w_head;
   logic [3:0]                 w_n;
   logic [7:0]                 w_mask;
   logic [7:0]                 w_data;
   logic [SHIFT_REG_WIDTH-1:0] w_frame;
   logic [BITS_WIDTH-1:0]      w_bits;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rd_ptr];

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign w_push = wr_i && !flush_i && (!w_full || w_pop);
   assign w_ovf  = wr_i && !flush_i && w_full && !w_pop;

   always_comb begin
      w_count_nxt = r_count;
      if (flush_i)
         w_count_nxt = '0;
      else if (w_push && !w_pop)
         w_count_nxt = r_count + CW'(1);
      else if (w_pop && !w_push)
         w_count_nxt = r_count - CW'(1);
   end

   // Sequencer next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_tx_we_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && tx_idle_i) begin
               w_state_nxt = S_LOAD;
               w_pop       = 1'b1;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_SETTLE;
            w_tx_we_nxt = 1'b1;
         end
         S_SETTLE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (tx_idle_i)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Frame image: start bit, N data bits, then ones (parity slot and stop bits)
   always_comb begin
      if (char_len_i < 4'd5)
         w_n = 4'd5;
      else if (char_len_i > 4'd8)
         w_n = 4'd8;
      else
         w_n = char_len_i;
      w_mask  = 8'hFF >> (4'd8 - w_n);
      w_data  = (w_head & w_mask) | ~w_mask;
      w_frame = {{(SHIFT_REG_WIDTH-9){1'b1}}, w_data, 1'b0};
      w_bits  = BITS_WIDTH'(w_n) + (stop2_i ? BITS_WIDTH'(3) : BITS_WIDTH'(2));
`ifdef SIA_TX_PARITY_EN
      if (parity_en_i) begin
         w_frame[IW'(w_n) + IW'(1)] = (^(w_head & w_mask)) ^ parity_odd_i;
         w_bits = w_bits + BITS_WIDTH'(1);
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (w_push)
         r_mem[r_wr_ptr] <= wdat_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         full_o     <= 1'b0;
         empty_o    <= 1'b1;
         overflow_o <= 1'b0;
         busy_o     <= 1'b0;
         tx_we_o    <= 1'b0;
         tx_dat_o   <= '1;
         tx_bits_o  <= '0;
         tx_baud_o  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         full_o     <= (w_count_nxt == CW'(DEPTH));
         empty_o    <= (w_count_nxt == '0);
         overflow_o <= overflow_o | w_ovf;
         busy_o     <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
         tx_we_o    <= w_tx_we_nxt;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (flush_i)
            r_rd_ptr <= r_wr_ptr;
         else if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_pop) begin
            tx_dat_o  <= w_frame;
            tx_bits_o <= w_bits;
            tx_baud_o <= baud_i;
         end
      end
   end

   assign count_o = r_count;

endmodule

// File: tb/tb_sia_tx_controller.sv
// Directed self-checking bench for sia_tx_controller (parity cases when SIA_TX_PARITY_EN is defined).
module tb_sia_tx_controller;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        wr_i;
   logic [7:0]  wdat_i;
   logic        flush_i;
   logic [3:0]  char_len_i;
   logic        stop2_i;
   logic        parity_en_i;
   logic        parity_odd_i;
   logic [31:0] baud_i;
   logic        tx_idle_i;
   logic        tx_we_o;
   logic [15:0] tx_dat_o;
   logic [4:0]  tx_bits_o;
   logic [31:0] tx_baud_o;
   logic        full_o;
   logic        empty_o;
   logic [3:0]  count_o;
   logic        overflow_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int we_cnt = 0;
   logic [15:0] cap_dat [$];
   int          cap_cyc [$];

   always #5 clk_i = ~clk_i;

   sia_tx_controller dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .wr_i         (wr_i),
      .wdat_i       (wdat_i),
      .flush_i      (flush_i),
      .char_len_i   (char_len_i),
      .stop2_i      (stop2_i),
`ifdef SIA_TX_PARITY_EN
      .parity_en_i  (parity_en_i),
      .parity_odd_i (parity_odd_i),
`endif
      .baud_i       (baud_i),
      .tx_idle_i    (tx_idle_i),
      .tx_we_o      (tx_we_o),
      .tx_dat_o     (tx_dat_o),
      .tx_bits_o    (tx_bits_o),
      .tx_baud_o    (tx_baud_o),
      .full_o       (full_o),
      .empty_o      (empty_o),
      .count_o      (count_o),
      .overflow_o   (overflow_o),
      .busy_o       (busy_o)
   );

   // Load-strobe monitor, sampled 3 ns after each rising edge
   always @(posedge clk_i) begin
      cyc++;
      #3;
      if (tx_we_o === 1'b1) begin
         we_cnt++;
         cap_dat.push_back(tx_dat_o);
         cap_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk_i);
      wr_i   = 1'b1;
      wdat_i = b;
      @(negedge clk_i);
      wr_i   = 1'b0;
   endtask

   // Called right after write_byte into an empty FIFO with the transmitter idle
   task automatic check_load(input string tag, input logic [15:0] dat,
                             input logic [4:0] bits, input logic [31:0] baud);
      @(negedge clk_i);
      check({tag, "_we_early"}, tx_we_o, 1'b0);
      @(negedge clk_i);
      check({tag, "_we"}, tx_we_o, 1'b1);
      check({tag, "_dat"}, tx_dat_o, dat);
      check({tag, "_bits"}, tx_bits_o, bits);
      check({tag, "_baud"}, tx_baud_o, baud);
      @(negedge clk_i);
      check({tag, "_we_once"}, tx_we_o, 1'b0);
      repeat (3) @(negedge clk_i);
   endtask

   task automatic wait_we(input string tag, input int target, input int max_cyc);
      int n = 0;
      while (we_cnt < target && n < max_cyc) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, "_timeout"}, 32'(we_cnt >= target), 32'd1);
   endtask

   initial begin
      int base;
      reset_i = 1'b1; wr_i = 1'b0; wdat_i = 8'h00; flush_i = 1'b0;
      char_len_i = 4'd8; stop2_i = 1'b0; parity_en_i = 1'b0; parity_odd_i = 1'b0;
      baud_i = 32'd4; tx_idle_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_count", count_o, 4'd0);
      check("rst_empty", empty_o, 1'b1);
      check("rst_full", full_o, 1'b0);
      check("rst_ovf", overflow_o, 1'b0);
      check("rst_we", tx_we_o, 1'b0);
      check("rst_dat", tx_dat_o, 16'hFFFF);
      check("rst_bits", tx_bits_o, 5'd0);
      check("rst_baud", tx_baud_o, 32'd0);
      check("rst_busy", busy_o, 1'b0);
      reset_i = 1'b0;

      // Basic framing and load latency
      write_byte(8'h55);
      check_load("t1", 16'hFEAA, 5'd10, 32'd4);
      char_len_i = 4'd5; stop2_i = 1'b1; baud_i = 32'd9;
      write_byte(8'hFF);
      check_load("t2_len5", 16'hFFFE, 5'd8, 32'd9);
      char_len_i = 4'd3;
      write_byte(8'hFF);
      check_load("t2_len3", 16'hFFFE, 5'd8, 32'd9);
      char_len_i = 4'd15;
      write_byte(8'h55);
      check_load("t2_len15", 16'hFEAA, 5'd11, 32'd9);
      char_len_i = 4'd6; stop2_i = 1'b0;
      write_byte(8'h15);
      check_load("t2_len6", 16'hFFAA, 5'd8, 32'd9);

      // Fill past full with the transmitter busy, then drain in order
      char_len_i = 4'd8; stop2_i = 1'b0;
      tx_idle_i = 1'b0;
      base = we_cnt;
      for (int i = 0; i < 9; i++) write_byte(8'(8'h10 + i));
      @(negedge clk_i);
      check("t3_full", full_o, 1'b1);
      check("t3_count", count_o, 4'd8);
      check("t3_ovf", overflow_o, 1'b1);
      check("t3_no_load", we_cnt, base);
      cap_dat.delete();
      tx_idle_i = 1'b1;
      wait_we("t3_drain", base + 8, 200);
      for (int i = 0; i < 8; i++) begin
         logic [15:0] got;
         got = (i < cap_dat.size()) ? cap_dat[i] : 16'h0000;
         check($sformatf("t3_order%0d", i), got, 16'hFE00 | (16'(8'h10 + i) << 1));
      end
      repeat (5) @(negedge clk_i);
      check("t3_empty", empty_o, 1'b1);
      check("t3_ovf_sticky", overflow_o, 1'b1);

      // Transmitter busy handshake and back-to-back spacing
      base = we_cnt;
      cap_cyc.delete();
      write_byte(8'hA5);
      write_byte(8'h5A);
      wait_we("t4_first", base + 1, 20);
      @(posedge clk_i); #1 tx_idle_i = 1'b0;
      repeat (100) @(posedge clk_i);
      check("t4_held", we_cnt, base + 1);
      #1 tx_idle_i = 1'b1;
      wait_we("t4_second", base + 2, 50);
      if (cap_cyc.size() >= 2)
         check("t4_spacing_ge103", 32'((cap_cyc[1] - cap_cyc[0]) >= 103), 32'd1);
      else
         check("t4_spacing_samples", cap_cyc.size(), 2);
      repeat (5) @(negedge clk_i);

      // Flush while the current frame is in WAIT
      base = we_cnt;
      write_byte(8'hC3);
      wait_we("t5_first", base + 1, 20);
      @(posedge clk_i); #1 tx_idle_i = 1'b0;
      write_byte(8'h11);
      write_byte(8'h22);
      @(negedge clk_i);
      check("t5_count", count_o, 4'd2);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("t5_empty", empty_o, 1'b1);
      check("t5_count0", count_o, 4'd0);
      check("t5_dat", tx_dat_o, 16'hFF86);
      check("t5_busy", busy_o, 1'b1);
      tx_idle_i = 1'b1;
      repeat (20) @(negedge clk_i);
      check("t5_no_load", we_cnt, base + 1);
      check("t5_idle", busy_o, 1'b0);

`ifdef SIA_TX_PARITY_EN
      parity_en_i = 1'b1; parity_odd_i = 1'b0;
      write_byte(8'h07);
      check_load("t6_even", 16'hFE0E, 5'd11, 32'd9);
      parity_odd_i = 1'b1;
      write_byte(8'h07);
      check_load("t6_odd", 16'hFC0E, 5'd11, 32'd9);
      parity_en_i = 1'b0;
`else
      write_byte(8'h07);
      check_load("t6_nopar", 16'hFE0E, 5'd10, 32'd9);
`endif

      // Reset in the middle of a frame
      base = we_cnt;
      write_byte(8'h33);
      wait_we("t7_load", base + 1, 20);
      @(posedge clk_i); #1 tx_idle_i = 1'b0;
      write_byte(8'h44);
      @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      check("t7_dat", tx_dat_o, 16'hFFFF);
      check("t7_bits", tx_bits_o, 5'd0);
      check("t7_baud", tx_baud_o, 32'd0);
      check("t7_busy", busy_o, 1'b0);
      check("t7_count", count_o, 4'd0);
      check("t7_ovf", overflow_o, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
